// File: rtl/pipe_ctrl_pkg.sv
// Pipeline control-word bit map and memory-stage FSM encodings.
// Shared with the execute and writeback stages.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_W         = 32;
  localparam int unsigned MEM_READ_BIT   = 21;
  localparam int unsigned MEM_WRITE_BIT  = 20;
  localparam int unsigned REG_WRITE_BIT  = 19;
  localparam int unsigned MEM_TO_REG_BIT = 18;
  localparam int unsigned ADDR_SEL_BIT   = 17;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic addr_sel;
  } mem_ctrl_t;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// IDLE/WAIT data-memory handshake sequencer.
// Optional abort-on-timeout counter and sticky error flag under MEM_TIMEOUT_EN.
module dmem_handshake_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic busy_o,
  output logic done_c,
  output logic abort_c,
  output logic mem_err_o
);

  mem_state_e state_q, state_d;
  logic       timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // WAIT-cycle counter; an ack on the final cycle still wins over the abort
  always_comb begin
    cnt_d = '0;
    err_d = err_q | abort_c;
    if ((state_q == ST_WAIT) && !ack_i && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_WAIT;
      ST_WAIT: if (ack_i || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == ST_WAIT);
    done_c  = (state_q == ST_WAIT) && ack_i;
    abort_c = timeout_hit && !ack_i;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: captures the execute bundle, runs loads/stores over req/ack,
// emits a registered writeback bundle. Optional timeout abort: define MEM_TIMEOUT_EN.
module mem_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEST_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DEST_W-1:0] ex_dest,
  input  logic [CTRL_W-1:0] ex_controls,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [DEST_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mem_ctrl_t         ctrl;
  logic              busy, done_c, abort_c;
  logic              accept, is_mem, start, dest_nz;
  logic [DATA_W-1:0] addr_mux, addr_word;
  logic              ctrl_unused;

  assign ctrl = '{
    mem_read:  ex_controls[MEM_READ_BIT],
    mem_write: ex_controls[MEM_WRITE_BIT],
    reg_write: ex_controls[REG_WRITE_BIT],
    addr_sel:  ex_controls[ADDR_SEL_BIT]
  };

  // Load data is always returned for loads, so mem_to_reg carries no extra information here
  assign ctrl_unused = ^{ex_controls[31:22], ex_controls[MEM_TO_REG_BIT],
                         ex_controls[16:0], addr_mux[1:0]};

  assign accept    = ex_valid && !busy;
  assign is_mem    = ctrl.mem_read || ctrl.mem_write;
  assign start     = accept && is_mem;
  assign dest_nz   = (ex_dest != '0);
  assign addr_mux  = ctrl.addr_sel ? ex_alu_out : ex_mem_addr;
  assign addr_word = {addr_mux[DATA_W-1:2], 2'b00};

  dmem_handshake_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .ack_i    (dmem_ack),
    .busy_o   (busy),
    .done_c   (done_c),
    .abort_c  (abort_c),
    .mem_err_o(mem_err)
  );

  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic              pend_load_q, pend_load_d, pend_rw_q, pend_rw_d;
  logic [DEST_W-1:0] pend_dest_q, pend_dest_d;
  logic [DATA_W-1:0] pend_alu_q, pend_alu_d;
  logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  // Capture on accept; completion or abort of an access produces the writeback
  always_comb begin
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_we_d      = dmem_we_q;
    pend_load_d    = pend_load_q;
    pend_rw_d      = pend_rw_q;
    pend_dest_d    = pend_dest_q;
    pend_alu_d     = pend_alu_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_dest_d      = wb_dest_q;
    wb_data_d      = wb_data_q;

    if (start) begin
      dmem_addr_d  = addr_word;
      dmem_wdata_d = ex_store_data;
      dmem_we_d    = ctrl.mem_write;
      pend_load_d  = !ctrl.mem_write;
      pend_rw_d    = !ctrl.mem_write && ctrl.reg_write && dest_nz;
      pend_dest_d  = ex_dest;
      pend_alu_d   = ex_alu_out;
    end else if (accept) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = ctrl.reg_write && dest_nz;
      wb_dest_d      = ex_dest;
      wb_data_d      = ex_alu_out;
    end

    if (done_c) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = pend_rw_q;
      wb_dest_d      = pend_dest_q;
      wb_data_d      = pend_load_q ? dmem_rdata : pend_alu_q;
    end else if (abort_c) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = 1'b0;
      wb_dest_d      = pend_dest_q;
      wb_data_d      = pend_alu_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_we_q      <= 1'b0;
      pend_load_q    <= 1'b0;
      pend_rw_q      <= 1'b0;
      pend_dest_q    <= '0;
      pend_alu_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_we_q      <= dmem_we_d;
      pend_load_q    <= pend_load_d;
      pend_rw_q      <= pend_rw_d;
      pend_dest_q    <= pend_dest_d;
      pend_alu_q     <= pend_alu_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_dest_q      <= wb_dest_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Request and stall both follow the registered FSM state, so reset drops them at once
  assign mem_stall    = busy;
  assign dmem_req     = busy;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed bundles, a delayed-ack memory model,
// and a monitor that checks every writeback pulse. MEM_TIMEOUT_EN adds the timeout case.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_out, ex_mem_addr, ex_store_data, ex_controls;
  logic [4:0]  ex_dest;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, mem_err;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  mem_stage #(.DATA_W(32), .DEST_W(5), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_alu_out   (ex_alu_out),
    .ex_mem_addr  (ex_mem_addr),
    .ex_store_data(ex_store_data),
    .ex_dest      (ex_dest),
    .ex_controls  (ex_controls),
    .mem_stall    (mem_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  // Memory model knobs
  logic        ack_en    = 1'b1;
  int          ack_delay = 0;
  logic [31:0] rd_val    = '0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_we    = 1'b0;
  logic        stray     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [4:0] dest, input logic [31:0] data);
    wb_exp_t e;
    e.we = we; e.dest = dest; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ctrl, input logic [31:0] alu, input logic [31:0] maddr,
                       input logic [31:0] sdata, input logic [4:0] dest);
    @(negedge clk);
    ex_valid      = 1'b1;
    ex_controls   = ctrl;
    ex_alu_out    = alu;
    ex_mem_addr   = maddr;
    ex_store_data = sdata;
    ex_dest       = dest;
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (mem_stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_mem(input int dly, input logic [31:0] rd, input logic [31:0] addr,
                         input logic we, input logic [31:0] wd);
    ack_delay = dly; rd_val = rd; exp_addr = addr; exp_we = we; exp_wdata = wd;
  endtask

  // Memory responder: checks the request on its first cycle, acks after ack_delay cycles
  initial begin
    int req_cnt;
    req_cnt    = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_ack) begin
        dmem_ack = 1'b0;
        req_cnt  = 0;
      end else if (stray && !dmem_req) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        stray      = 1'b0;
      end else if (dmem_req && ack_en) begin
        if (req_cnt == 0) begin
          check("dmem_addr", dmem_addr, exp_addr);
          check("dmem_we", 32'(dmem_we), 32'(exp_we));
          check("dmem_wdata", dmem_wdata, exp_wdata);
        end
        if (req_cnt == ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd_val;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_data %h dest %0d, required no writeback", wb_data, wb_dest);
        end else begin
          e = exp_q.pop_front();
          check("wb_reg_write", 32'(wb_reg_write), 32'(e.we));
          check("wb_dest", 32'(wb_dest), 32'(e.dest));
          check("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_controls = '0; ex_alu_out = '0; ex_mem_addr = '0;
    ex_store_data = '0; ex_dest = '0;
    repeat (2) @(negedge clk);

    check("rst_mem_stall", 32'(mem_stall), 0);
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_dmem_we", 32'(dmem_we), 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 0);
    check("rst_wb_dest", 32'(wb_dest), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_err", 32'(mem_err), 0);
    rst_n = 1'b1;

    // ALU-only, reg_write
    issue(32'h0008_0000, 32'h0000_1234, 32'h0, 32'h0, 5'd3);
    push_exp(1'b1, 5'd3, 32'h0000_1234);
    idle();
    check("alu_no_stall", 32'(mem_stall), 0);

    // Back-to-back ALU ops: dest 0 suppresses write, then upper bits only (no reg_write)
    issue(32'h0008_0000, 32'h0000_00AA, 32'h0, 32'h0, 5'd0);
    push_exp(1'b0, 5'd0, 32'h0000_00AA);
    issue(32'hFFC0_0000, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd12);
    push_exp(1'b0, 5'd12, 32'h0BAD_F00D);
    idle();

    // Load, immediate address 0x106, ack after 3 waiting cycles
    set_mem(3, 32'hDEAD_BEEF, 32'h0000_0104, 1'b0, 32'h0000_0055);
    issue(32'h002C_0000, 32'h0000_9999, 32'h0000_0106, 32'h0000_0055, 5'd7);
    push_exp(1'b1, 5'd7, 32'hDEAD_BEEF);
    idle();
    wait_stall(n);
    check("load_stall_cycles", 32'(n), 4);

    // Store via ALU address, immediate ack; reg_write bit set but must be ignored
    set_mem(0, 32'h0, 32'h0000_0200, 1'b1, 32'hA5A5_A5A5);
    issue(32'h001A_0000, 32'h0000_0200, 32'h0000_0333, 32'hA5A5_A5A5, 5'd5);
    push_exp(1'b0, 5'd5, 32'h0000_0200);
    idle();
    wait_stall(n);
    check("store_stall_cycles", 32'(n), 1);

    // Load to x0 via ALU address 0x300B
    set_mem(1, 32'h1111_2222, 32'h0000_3008, 1'b0, 32'h0000_0001);
    issue(32'h002E_0000, 32'h0000_300B, 32'h0000_0444, 32'h0000_0001, 5'd0);
    push_exp(1'b0, 5'd0, 32'h1111_2222);
    idle();
    wait_stall(n);
    check("load_x0_stall_cycles", 32'(n), 2);

    // Read and write both set: store wins, no register write
    set_mem(2, 32'hFFFF_FFFF, 32'h0000_0040, 1'b1, 32'h0000_5555);
    issue(32'h003C_0000, 32'h0000_0077, 32'h0000_0041, 32'h0000_5555, 5'd9);
    push_exp(1'b0, 5'd9, 32'h0000_0077);
    idle();
    wait_stall(n);
    check("rdwr_stall_cycles", 32'(n), 3);

    // Stray ack while idle changes nothing
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_wb_valid", 32'(wb_valid), 0);
    check("stray_wb_data", wb_data, 32'h0000_0077);
    check("stray_stall", 32'(mem_stall), 0);
    check("stray_req", 32'(dmem_req), 0);

`ifndef MEM_TIMEOUT_EN
    // Without the timeout option an unanswered request waits indefinitely
    ack_en = 1'b0;
    issue(32'h002C_0000, 32'h0, 32'h0000_0010, 32'h0, 5'd2);
    idle();
    repeat (20) @(negedge clk);
    check("hold_stall", 32'(mem_stall), 1);
    check("hold_req", 32'(dmem_req), 1);
    check("hold_mem_err", 32'(mem_err), 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Reset two cycles into WAIT
    ack_en = 1'b0;
    issue(32'h002C_0000, 32'h0000_0001, 32'h0000_0020, 32'h0, 5'd6);
    push_exp(1'b1, 5'd6, 32'hCCCC_CCCC);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_req", 32'(dmem_req), 0);
    check("rst_wait_stall", 32'(mem_stall), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;

    issue(32'h0008_0000, 32'h0000_CAFE, 32'h0, 32'h0, 5'd4);
    push_exp(1'b1, 5'd4, 32'h0000_CAFE);
    idle();
    set_mem(0, 32'h7654_3210, 32'h0000_0080, 1'b0, 32'h0);
    issue(32'h002C_0000, 32'h0, 32'h0000_0083, 32'h0, 5'd31);
    push_exp(1'b1, 5'd31, 32'h7654_3210);
    idle();
    wait_stall(n);
    check("post_rst_stall_cycles", 32'(n), 1);

`ifdef MEM_TIMEOUT_EN
    // Unanswered load aborts after 8 WAIT cycles
    ack_en = 1'b0;
    issue(32'h002C_0000, 32'h0000_0ABC, 32'h0000_0100, 32'h0, 5'd8);
    push_exp(1'b0, 5'd8, 32'h0000_0ABC);
    idle();
    wait_stall(n);
    check("timeout_stall_cycles", 32'(n), 8);
    check("timeout_req", 32'(dmem_req), 0);
    @(negedge clk);
    check("timeout_mem_err", 32'(mem_err), 1);
    ack_en = 1'b1;
    issue(32'h0008_0000, 32'h0000_0F0F, 32'h0, 32'h0, 5'd1);
    push_exp(1'b1, 5'd1, 32'h0000_0F0F);
    idle();
    @(negedge clk);
    check("timeout_err_sticky", 32'(mem_err), 1);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
